// File: rtl/count_sequencer.sv
// count_sequencer: run/stop/step controller for a W-bit counter, driven by
// prescaled enable ticks in the ClkIn domain.
// Ports: ClkIn/Rst (async, active-high); StartBtn/StopBtn/StepBtn raw
// buttons; RateSel tick rate; AutoStop/Limit terminal count;
// Count/Tick/Wrap registered count + pulses; Busy (RUN); State encoding.
module count_sequencer #(
  parameter int N = 5,
  parameter int W = 4
) (
  input  logic         ClkIn,
  input  logic         Rst,
  input  logic         StartBtn,
  input  logic         StopBtn,
  input  logic         StepBtn,
  input  logic [1:0]   RateSel,
  input  logic         AutoStop,
  input  logic [W-1:0] Limit,
  output logic [W-1:0] Count,
  output logic         Tick,
  output logic         Wrap,
  output logic         Busy,
  output logic [1:0]   State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_hist;
  logic [2:0]     w_btn;
  logic [2:0]     w_pulse;
  logic           w_start;
  logic           w_stop;
  logic           w_step;
  logic [N+1:0]   r_presc;
  logic [N+1:0]   w_mask;
  logic           w_evt;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_cnt_nxt;
  logic [W-1:0]   w_cnt_p1;
  logic           w_inc;
  logic           w_presc_clr;
  logic           r_tick;
  logic           r_wrap;

  assign w_btn = {StepBtn, StopBtn, StartBtn};

  // two sync stages plus a history flop; one pulse per rising edge
  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_pulse = r_sync2 & ~r_hist;
  assign w_start = w_pulse[0];
  assign w_stop  = w_pulse[1];
  assign w_step  = w_pulse[2];

  // low K = N-2+RateSel bits all ones marks a tick event
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N + 2; i++) begin
      w_mask[i] = (i < (N - 2 + int'(RateSel)));
    end
  end

  assign w_evt = (r_state == S_RUN) &&
                 ((r_presc & w_mask) == w_mask);

  assign w_cnt_p1 = r_count + W'(1);

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop outranks Start, which outranks Step
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_count;
    w_inc       = 1'b0;
    w_presc_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_stop) begin
          if (w_start) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
            w_presc_clr = 1'b1;
          end else if (w_step) begin
            w_inc = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_state_nxt = S_PAUSE;
        end else if (w_evt) begin
          w_inc = 1'b1;
          if (AutoStop && (w_cnt_p1 == Limit)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_PAUSE: begin
        if (w_stop) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_state_nxt = S_RUN;
          w_presc_clr = 1'b1;
        end else if (w_step) begin
          w_inc = 1'b1;
          if (AutoStop && (w_cnt_p1 == Limit)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
          w_presc_clr = 1'b1;
        end
      end
    endcase
    if (w_inc) begin
      w_cnt_nxt = w_cnt_p1;
    end
  end

  always_ff @(posedge ClkIn or posedge Rst) begin
    if (Rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      r_tick  <= w_inc;
      r_wrap  <= w_inc && (r_count == '1);
      if (w_presc_clr) begin
        r_presc <= '0;
      end else if (r_state == S_RUN) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    Count = r_count;
    Tick  = r_tick;
    Wrap  = r_wrap;
    State = r_state;
    Busy  = (r_state == S_RUN);
  end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed stimulus with a tick scoreboard; every
// Tick is popped and checked for count, wrap, state and cycle.
module tb_count_sequencer;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_STOP  = 3'b010;
  localparam logic [2:0] B_STEP  = 3'b100;

  logic       ClkIn = 1'b0;
  logic       Rst;
  logic       StartBtn;
  logic       StopBtn;
  logic       StepBtn;
  logic [1:0] RateSel;
  logic       AutoStop;
  logic [3:0] Limit;
  logic [3:0] Count;
  logic       Tick;
  logic       Wrap;
  logic       Busy;
  logic [1:0] State;

  typedef struct {
    logic [3:0] cnt;
    logic       wrap;
    logic [1:0] st;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   c;
  int   c2;

  count_sequencer #(.N(5), .W(4)) dut (
    .ClkIn(ClkIn),
    .Rst(Rst),
    .StartBtn(StartBtn),
    .StopBtn(StopBtn),
    .StepBtn(StepBtn),
    .RateSel(RateSel),
    .AutoStop(AutoStop),
    .Limit(Limit),
    .Count(Count),
    .Tick(Tick),
    .Wrap(Wrap),
    .Busy(Busy),
    .State(State)
  );

  always #5 ClkIn = ~ClkIn;

  always @(posedge ClkIn) cyc <= cyc + 1;

  task automatic push(input logic [3:0] cn, input logic wr,
                      input logic [1:0] st, input int cy);
    exp_t x;
    x.cnt  = cn;
    x.wrap = wr;
    x.st   = st;
    x.cyc  = cy;
    q.push_back(x);
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // raise buttons at the current negedge, hold, release
  task automatic press(input logic [2:0] b, input int hold);
    StartBtn = b[0];
    StopBtn  = b[1];
    StepBtn  = b[2];
    repeat (hold) @(negedge ClkIn);
    StartBtn = 1'b0;
    StopBtn  = 1'b0;
    StepBtn  = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge ClkIn);
  endtask

  always @(negedge ClkIn) begin
    if (!Rst && Tick) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL tick_unexpected: count=%0d wrap=%0b state=%0d cyc=%0d, none expected",
                 Count, Wrap, State, cyc);
      end else begin
        e = q.pop_front();
        if (Count !== e.cnt || Wrap !== e.wrap ||
            State !== e.st || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL tick: got count=%0d wrap=%0b state=%0d cyc=%0d, want count=%0d wrap=%0b state=%0d cyc=%0d",
                   Count, Wrap, State, cyc, e.cnt, e.wrap, e.st, e.cyc);
        end
      end
    end
  end

  initial begin
    Rst      = 1'b1;
    StartBtn = 1'b0;
    StopBtn  = 1'b0;
    StepBtn  = 1'b0;
    RateSel  = 2'd0;
    AutoStop = 1'b0;
    Limit    = 4'd0;
    repeat (3) @(negedge ClkIn);
    check("rst_count", int'(Count), 0);
    check("rst_state", int'(State), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_tick", int'(Tick), 0);
    check("rst_wrap", int'(Wrap), 0);
    Rst = 1'b0;
    repeat (20) @(negedge ClkIn);
    check("idle_count", int'(Count), 0);
    check("idle_state", int'(State), 0);

    // run at 8 cycles/tick through a wrap, AutoStop off
    c = cyc;
    for (int i = 1; i <= 17; i++)
      push(4'(i % 16), (i == 16), 2'd1, c + 3 + 8 * i);
    press(B_START, 3);
    check("run_state", int'(State), 1);
    check("run_busy", int'(Busy), 1);
    check("run_count0", int'(Count), 0);

    // stop lands on the tick-event edge c+147: no increment
    wait_until(c + 144);
    press(B_STOP, 3);
    check("pause_state", int'(State), 2);
    check("pause_count", int'(Count), 1);
    repeat (20) @(negedge ClkIn);
    check("pause_frozen", int'(Count), 1);

    // three steps, the last held 100 cycles
    for (int j = 0; j < 3; j++) begin
      c = cyc;
      push(4'(2 + j), 1'b0, 2'd2, c + 3);
      press(B_STEP, (j == 2) ? 100 : 3);
      repeat (4) @(negedge ClkIn);
    end
    check("step_count", int'(Count), 4);
    check("step_state", int'(State), 2);

    // resume, then Stop+Start together
    c = cyc;
    push(4'd5, 1'b0, 2'd1, c + 11);
    push(4'd6, 1'b0, 2'd1, c + 19);
    press(B_START, 3);
    check("resume_state", int'(State), 1);
    wait_until(c + 20);
    press(B_STOP | B_START, 3);
    check("stopstart_state", int'(State), 2);
    check("stopstart_count", int'(Count), 6);
    repeat (4) @(negedge ClkIn);
    press(B_STOP, 3);
    check("stop2_state", int'(State), 0);
    check("stop2_count", int'(Count), 0);
    repeat (4) @(negedge ClkIn);

    // slowest rate: 64 cycles/tick
    RateSel = 2'd3;
    c = cyc;
    push(4'd1, 1'b0, 2'd1, c + 3 + 64);
    push(4'd2, 1'b0, 2'd1, c + 3 + 128);
    press(B_START, 3);
    wait_until(c + 140);
    press(B_STOP, 3);
    repeat (4) @(negedge ClkIn);
    press(B_STOP, 3);
    check("rate3_idle", int'(State), 0);
    RateSel = 2'd0;
    repeat (4) @(negedge ClkIn);

    // AutoStop at Limit=5
    AutoStop = 1'b1;
    Limit    = 4'd5;
    c = cyc;
    for (int i = 1; i <= 5; i++)
      push(4'(i), 1'b0, (i == 5) ? 2'd3 : 2'd1, c + 3 + 8 * i);
    press(B_START, 3);
    wait_until(c + 44);
    check("done_state", int'(State), 3);
    check("done_busy", int'(Busy), 0);
    check("done_count", int'(Count), 5);
    repeat (200) @(negedge ClkIn);
    check("done_hold", int'(Count), 5);
    press(B_STEP, 3);
    repeat (4) @(negedge ClkIn);
    check("done_step_ign", int'(Count), 5);
    check("done_step_st", int'(State), 3);

    // Limit=0 equals Count on entry: stops only at the wrap
    Limit = 4'd0;
    c = cyc;
    for (int i = 1; i <= 16; i++)
      push(4'(i % 16), (i == 16), (i == 16) ? 2'd3 : 2'd1,
           c + 3 + 8 * i);
    press(B_START, 3);
    check("restart_count", int'(Count), 0);
    check("restart_state", int'(State), 1);
    wait_until(c + 132);
    check("lim0_state", int'(State), 3);
    check("lim0_count", int'(Count), 0);
    repeat (4) @(negedge ClkIn);

    // DONE at 3, Stop keeps the count, IDLE step increments
    Limit = 4'd3;
    c = cyc;
    for (int i = 1; i <= 3; i++)
      push(4'(i), 1'b0, (i == 3) ? 2'd3 : 2'd1, c + 3 + 8 * i);
    press(B_START, 3);
    wait_until(c + 28);
    check("lim3_state", int'(State), 3);
    press(B_STOP, 3);
    check("done_stop_st", int'(State), 0);
    check("done_stop_cnt", int'(Count), 3);
    repeat (4) @(negedge ClkIn);
    c = cyc;
    push(4'd4, 1'b0, 2'd0, c + 3);
    press(B_STEP, 3);
    check("idle_step", int'(Count), 4);
    AutoStop = 1'b0;
    repeat (4) @(negedge ClkIn);

    // asynchronous reset mid-count
    c = cyc;
    push(4'd1, 1'b0, 2'd1, c + 11);
    push(4'd2, 1'b0, 2'd1, c + 19);
    press(B_START, 3);
    wait_until(c + 22);
    #2 Rst = 1'b1;
    #1;
    check("arst_count", int'(Count), 0);
    check("arst_state", int'(State), 0);
    check("arst_busy", int'(Busy), 0);
    check("arst_tick", int'(Tick), 0);
    check("arst_wrap", int'(Wrap), 0);
    @(negedge ClkIn);
    Rst = 1'b0;
    repeat (20) @(negedge ClkIn);
    check("post_rst_count", int'(Count), 0);
    check("post_rst_state", int'(State), 0);

    check("ticks_pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
